// File: rtl/uart_frame_streamer_if.sv
// -----------------------------------------------------------------------------
// uart_frame_streamer_if
// Purpose : groups the frame-request and transmit-status signals of
//           uart_frame_streamer.
// Signals : data_in    frame payload, MSB byte sent first
//           start      one-shot frame request
//           enable     periodic-mode request
//           tx_out     UART serial line, idles high
//           busy       frame or gap in progress
//           frame_done one-cycle pulse after the last stop bit
//           byte_index index of the byte on the line, 0 = MSB byte
// Modports: master drives requests (source), slave is the streamer.
// -----------------------------------------------------------------------------
interface uart_frame_streamer_if #(
  parameter int unsigned DATA_WIDTH       = 8320,
  parameter int unsigned DATA_WIDTH_BASE2 = 14
);
  logic [DATA_WIDTH-1:0]       data_in;
  logic                        start;
  logic                        enable;
  logic                        tx_out;
  logic                        busy;
  logic                        frame_done;
  logic [DATA_WIDTH_BASE2-1:0] byte_index;

  modport master (
    output data_in, start, enable,
    input  tx_out, busy, frame_done, byte_index
  );

  modport slave (
    input  data_in, start, enable,
    output tx_out, busy, frame_done, byte_index
  );
endinterface

// File: rtl/uart_frame_streamer.sv
// -----------------------------------------------------------------------------
// uart_frame_streamer
// Purpose : serialises a DATA_WIDTH-bit frame, MSB byte first, as UART
//           characters (start, 8 data bits LSB first, optional parity,
//           1 or 2 stop bits). One-shot on start, or repeating with an
//           idle-high gap while enable is held.
// Ports   : clk_in  system clock
//           reset   asynchronous active-high reset
//           bus     uart_frame_streamer_if.slave (data_in, start, enable,
//                   tx_out, busy, frame_done, byte_index)
// -----------------------------------------------------------------------------
module uart_frame_streamer #(
  parameter int unsigned DATA_WIDTH              = 8320,
  parameter int unsigned DATA_WIDTH_BASE2        = 14,
  parameter int unsigned UART_TICKS_PER_BIT      = 65,
  parameter int unsigned UART_TICKS_PER_BIT_SIZE = 7,
  parameter int unsigned GAP_TICKS               = 15,
  parameter int unsigned GAP_TICKS_WIDTH         = 4,
  parameter int unsigned PARITY_MODE             = 0,
  parameter int unsigned STOP_BITS               = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  uart_frame_streamer_if.slave  bus
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned GAP_LAST  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam logic        PAR_ODD   = 1'(PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t                        r_state,  w_nxt_state;
  logic [UART_TICKS_PER_BIT_SIZE-1:0] r_tick, w_nxt_tick;
  logic [2:0]                    r_bit,    w_nxt_bit;
  logic [DATA_WIDTH_BASE2-1:0]   r_byte_index, w_nxt_idx;
  logic [GAP_TICKS_WIDTH-1:0]    r_gap,    w_nxt_gap;
  logic [DATA_WIDTH-1:0]         r_shift,  w_nxt_shift;
  logic                          r_tx,     w_nxt_tx;
  logic                          r_busy,   w_nxt_busy;
  logic                          r_done,   w_nxt_done;
  logic [7:0]                    w_nxt_byte;
  logic                          w_tick_last;

  assign w_tick_last = (r_tick == UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1));

  // Next-state and next-register values; line level is decoded from the
  // next state so tx_out changes on the same edge the state does.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tick  = r_tick;
    w_nxt_bit   = r_bit;
    w_nxt_idx   = r_byte_index;
    w_nxt_gap   = r_gap;
    w_nxt_shift = r_shift;
    w_nxt_done  = 1'b0;
    w_nxt_byte  = 8'h00;
    w_nxt_tx    = 1'b1;
    w_nxt_busy  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start || bus.enable) begin
          w_nxt_state = S_START;
          w_nxt_shift = bus.data_in;
          w_nxt_idx   = '0;
          w_nxt_tick  = '0;
          w_nxt_bit   = '0;
        end
      end
      S_START: begin
        if (w_tick_last) begin
          w_nxt_tick  = '0;
          w_nxt_bit   = '0;
          w_nxt_state = S_DATA;
        end else begin
          w_nxt_tick = r_tick + UART_TICKS_PER_BIT_SIZE'(1);
        end
      end
      S_DATA: begin
        if (w_tick_last) begin
          w_nxt_tick = '0;
          if (r_bit == 3'd7) begin
            w_nxt_bit   = '0;
            w_nxt_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            w_nxt_bit = r_bit + 3'd1;
          end
        end else begin
          w_nxt_tick = r_tick + UART_TICKS_PER_BIT_SIZE'(1);
        end
      end
      S_PARITY: begin
        if (w_tick_last) begin
          w_nxt_tick  = '0;
          w_nxt_bit   = '0;
          w_nxt_state = S_STOP;
        end else begin
          w_nxt_tick = r_tick + UART_TICKS_PER_BIT_SIZE'(1);
        end
      end
      S_STOP: begin
        if (w_tick_last) begin
          w_nxt_tick = '0;
          if (r_bit == 3'(STOP_BITS - 1)) begin
            w_nxt_bit = '0;
            if (r_byte_index < DATA_WIDTH_BASE2'(NUM_BYTES - 1)) begin
              // next byte of the same frame moves into the MSB slot
              w_nxt_idx   = r_byte_index + DATA_WIDTH_BASE2'(1);
              w_nxt_shift = r_shift << 8;
              w_nxt_state = S_START;
            end else begin
              w_nxt_done = 1'b1;
              if (!bus.enable) begin
                w_nxt_state = S_IDLE;
              end else if (GAP_TICKS > 0) begin
                w_nxt_gap   = '0;
                w_nxt_state = S_GAP;
              end else begin
                w_nxt_shift = bus.data_in;
                w_nxt_idx   = '0;
                w_nxt_state = S_START;
              end
            end
          end else begin
            w_nxt_bit = r_bit + 3'd1;
          end
        end else begin
          w_nxt_tick = r_tick + UART_TICKS_PER_BIT_SIZE'(1);
        end
      end
      S_GAP: begin
        if (!bus.enable) begin
          w_nxt_gap   = '0;
          w_nxt_state = S_IDLE;
        end else if (r_gap == GAP_TICKS_WIDTH'(GAP_LAST)) begin
          w_nxt_gap   = '0;
          w_nxt_shift = bus.data_in;
          w_nxt_idx   = '0;
          w_nxt_tick  = '0;
          w_nxt_bit   = '0;
          w_nxt_state = S_START;
        end else begin
          w_nxt_gap = r_gap + GAP_TICKS_WIDTH'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    w_nxt_byte = w_nxt_shift[DATA_WIDTH-1 -: 8];
    w_nxt_busy = (w_nxt_state != S_IDLE);
    case (w_nxt_state)
      S_START:  w_nxt_tx = 1'b0;
      S_DATA:   w_nxt_tx = w_nxt_byte[w_nxt_bit];
      S_PARITY: w_nxt_tx = (^w_nxt_byte) ^ PAR_ODD;
      default:  w_nxt_tx = 1'b1;
    endcase
  end

  // State and output registers; reset drives the line high immediately.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_bit        <= '0;
      r_byte_index <= '0;
      r_gap        <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_tick       <= w_nxt_tick;
      r_bit        <= w_nxt_bit;
      r_byte_index <= w_nxt_idx;
      r_gap        <= w_nxt_gap;
      r_shift      <= w_nxt_shift;
      r_tx         <= w_nxt_tx;
      r_busy       <= w_nxt_busy;
      r_done       <= w_nxt_done;
    end
  end

  assign bus.tx_out     = r_tx;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign bus.byte_index = r_byte_index;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_streamer
// Purpose : directed checks of uart_frame_streamer with a 16-bit frame and
//           4 clocks per bit; four instances cover no parity, even parity,
//           odd parity, and two stop bits with a 15-cycle periodic gap.
// -----------------------------------------------------------------------------
module tb_uart_frame_streamer;

  localparam int unsigned DW  = 16;
  localparam int unsigned DWB = 5;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // Expected line levels, one entry per bit-time, first bit at the MSB.
  logic [19:0] e_4c01_p0   = 20'b0_00110010_1_0_10000000_1;
  logic [21:0] e_4c01_even = 22'b0_00110010_1_1_0_10000000_1_1;
  logic [21:0] e_4c01_odd  = 22'b0_00110010_0_1_0_10000000_0_1;
  logic [21:0] e_4c01_s2   = 22'b0_00110010_11_0_10000000_11;
  logic [21:0] e_a55a_s2   = 22'b0_10100101_11_0_01011010_11;

  uart_frame_streamer_if #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB)) if0 ();
  uart_frame_streamer_if #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB)) if1 ();
  uart_frame_streamer_if #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB)) if2 ();
  uart_frame_streamer_if #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB)) if3 ();

  uart_frame_streamer #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB), .UART_TICKS_PER_BIT(4),
    .UART_TICKS_PER_BIT_SIZE(3), .GAP_TICKS(15), .GAP_TICKS_WIDTH(4),
    .PARITY_MODE(0), .STOP_BITS(1)) u0 (.clk_in(clk), .reset(rst), .bus(if0));
  uart_frame_streamer #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB), .UART_TICKS_PER_BIT(4),
    .UART_TICKS_PER_BIT_SIZE(3), .GAP_TICKS(15), .GAP_TICKS_WIDTH(4),
    .PARITY_MODE(1), .STOP_BITS(1)) u1 (.clk_in(clk), .reset(rst), .bus(if1));
  uart_frame_streamer #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB), .UART_TICKS_PER_BIT(4),
    .UART_TICKS_PER_BIT_SIZE(3), .GAP_TICKS(15), .GAP_TICKS_WIDTH(4),
    .PARITY_MODE(2), .STOP_BITS(1)) u2 (.clk_in(clk), .reset(rst), .bus(if2));
  uart_frame_streamer #(.DATA_WIDTH(DW), .DATA_WIDTH_BASE2(DWB), .UART_TICKS_PER_BIT(4),
    .UART_TICKS_PER_BIT_SIZE(3), .GAP_TICKS(15), .GAP_TICKS_WIDTH(4),
    .PARITY_MODE(0), .STOP_BITS(2)) u3 (.clk_in(clk), .reset(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.data_in = '0; if0.start = 1'b0; if0.enable = 1'b0;
    if1.data_in = '0; if1.start = 1'b0; if1.enable = 1'b0;
    if2.data_in = '0; if2.start = 1'b0; if2.enable = 1'b0;
    if3.data_in = '0; if3.start = 1'b0; if3.enable = 1'b0;
    #3;
    n_vec++; if (if0.tx_out !== 1'b1) begin n_err++; $display("FAIL reset_tx0 got %b exp 1", if0.tx_out); end
    n_vec++; if (if3.tx_out !== 1'b1) begin n_err++; $display("FAIL reset_tx3 got %b exp 1", if3.tx_out); end
    n_vec++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
    n_vec++; if (if0.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", if0.frame_done); end
    n_vec++; if (if0.byte_index !== 5'd0) begin n_err++; $display("FAIL reset_idx got %0d exp 0", if0.byte_index); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    n_vec++; if (if1.tx_out !== 1'b1 || if1.busy !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset tx=%b busy=%b exp tx=1 busy=0", if1.tx_out, if1.busy);
    end
  endtask

  task automatic test_single();
    if0.data_in = 16'h4C01; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      n_vec++; if (if0.tx_out !== e_4c01_p0[19 - c/4]) begin
        n_err++; $display("FAIL single_tx c=%0d got %b exp %b", c, if0.tx_out, e_4c01_p0[19 - c/4]);
      end
      if (c == 0) begin
        n_vec++; if (if0.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", if0.busy); end
      end
      if (c == 39 || c == 40) begin
        n_vec++; if (if0.byte_index !== 5'(c / 40)) begin
          n_err++; $display("FAIL single_idx c=%0d got %0d exp %0d", c, if0.byte_index, c / 40);
        end
      end
      if (c == 79) begin
        n_vec++; if (if0.frame_done !== 1'b0) begin n_err++; $display("FAIL single_early_done got 1 exp 0"); end
      end
      tick();
    end
    n_vec++; if (if0.frame_done !== 1'b1) begin n_err++; $display("FAIL single_done got %b exp 1", if0.frame_done); end
    n_vec++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got %b exp 0", if0.busy); end
    tick();
    n_vec++; if (if0.frame_done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse got %b exp 0", if0.frame_done); end
  endtask

  task automatic test_parity();
    if1.data_in = 16'h4C01; if1.start = 1'b1;
    if2.data_in = 16'h4C01; if2.start = 1'b1;
    tick();
    if1.start = 1'b0; if2.start = 1'b0;
    for (int c = 0; c < 88; c++) begin
      n_vec++; if (if1.tx_out !== e_4c01_even[21 - c/4]) begin
        n_err++; $display("FAIL even_tx c=%0d got %b exp %b", c, if1.tx_out, e_4c01_even[21 - c/4]);
      end
      n_vec++; if (if2.tx_out !== e_4c01_odd[21 - c/4]) begin
        n_err++; $display("FAIL odd_tx c=%0d got %b exp %b", c, if2.tx_out, e_4c01_odd[21 - c/4]);
      end
      tick();
    end
    n_vec++; if (if1.frame_done !== 1'b1 || if1.busy !== 1'b0) begin
      n_err++; $display("FAIL even_done done=%b busy=%b exp done=1 busy=0", if1.frame_done, if1.busy);
    end
    n_vec++; if (if2.frame_done !== 1'b1 || if2.busy !== 1'b0) begin
      n_err++; $display("FAIL odd_done done=%b busy=%b exp done=1 busy=0", if2.frame_done, if2.busy);
    end
  endtask

  task automatic test_periodic();
    if3.data_in = 16'h4C01; if3.enable = 1'b1;
    tick();
    for (int c = 0; c < 191; c++) begin
      if (c == 20) if3.data_in = 16'hA55A;
      if (c == 113) if3.enable = 1'b0;
      if (c < 88) begin
        n_vec++; if (if3.tx_out !== e_4c01_s2[21 - c/4]) begin
          n_err++; $display("FAIL periodic_f1 c=%0d got %b exp %b", c, if3.tx_out, e_4c01_s2[21 - c/4]);
        end
      end else if (c < 103) begin
        n_vec++; if (if3.tx_out !== 1'b1 || if3.busy !== 1'b1) begin
          n_err++; $display("FAIL periodic_gap c=%0d tx=%b busy=%b exp tx=1 busy=1", c, if3.tx_out, if3.busy);
        end
      end else begin
        n_vec++; if (if3.tx_out !== e_a55a_s2[21 - (c-103)/4]) begin
          n_err++; $display("FAIL periodic_f2 c=%0d got %b exp %b", c, if3.tx_out, e_a55a_s2[21 - (c-103)/4]);
        end
      end
      if (c == 88) begin
        n_vec++; if (if3.frame_done !== 1'b1) begin n_err++; $display("FAIL periodic_done1 got %b exp 1", if3.frame_done); end
      end
      tick();
    end
    n_vec++; if (if3.frame_done !== 1'b1 || if3.busy !== 1'b0) begin
      n_err++; $display("FAIL periodic_end done=%b busy=%b exp done=1 busy=0", if3.frame_done, if3.busy);
    end
  endtask

  task automatic test_enable_drop();
    int dones;
    int lows;
    dones = 0; lows = 0;
    if0.data_in = 16'h4C01; if0.enable = 1'b1;
    tick();
    for (int c = 0; c < 120; c++) begin
      if (c == 10) if0.enable = 1'b0;
      if (c < 80) begin
        n_vec++; if (if0.tx_out !== e_4c01_p0[19 - c/4]) begin
          n_err++; $display("FAIL drop_tx c=%0d got %b exp %b", c, if0.tx_out, e_4c01_p0[19 - c/4]);
        end
      end
      if (c == 80) begin
        n_vec++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL drop_busy got %b exp 0", if0.busy); end
      end
      if (if0.frame_done === 1'b1) dones++;
      if (c >= 80 && if0.tx_out !== 1'b1) lows++;
      tick();
    end
    n_vec++; if (dones !== 1) begin n_err++; $display("FAIL drop_done_count got %0d exp 1", dones); end
    n_vec++; if (lows !== 0) begin n_err++; $display("FAIL drop_idle_line got %0d low cycles exp 0", lows); end
  endtask

  task automatic test_reset_mid_frame();
    if0.data_in = 16'h4C01; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int c = 0; c < 56; c++) tick();
    n_vec++; if (if0.tx_out !== 1'b0 || if0.byte_index !== 5'd1) begin
      n_err++; $display("FAIL pre_reset tx=%b idx=%0d exp tx=0 idx=1", if0.tx_out, if0.byte_index);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (if0.tx_out !== 1'b1) begin n_err++; $display("FAIL async_reset_tx got %b exp 1", if0.tx_out); end
    n_vec++; if (if0.busy !== 1'b0 || if0.byte_index !== 5'd0) begin
      n_err++; $display("FAIL async_reset_state busy=%b idx=%0d exp busy=0 idx=0", if0.busy, if0.byte_index);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      n_vec++; if (if0.tx_out !== e_4c01_p0[19 - c/4]) begin
        n_err++; $display("FAIL post_reset_tx c=%0d got %b exp %b", c, if0.tx_out, e_4c01_p0[19 - c/4]);
      end
      if (c == 0) begin
        n_vec++; if (if0.byte_index !== 5'd0) begin n_err++; $display("FAIL post_reset_idx got %0d exp 0", if0.byte_index); end
      end
      tick();
    end
    n_vec++; if (if0.frame_done !== 1'b1) begin n_err++; $display("FAIL post_reset_done got %b exp 1", if0.frame_done); end
  endtask

  task automatic test_start_while_busy();
    int dones;
    int lows;
    dones = 0; lows = 0;
    if0.data_in = 16'h4C01; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int c = 0; c < 160; c++) begin
      if (c == 30 || c == 79) if0.start = 1'b1;
      if (c == 31 || c == 80) if0.start = 1'b0;
      if (c < 80) begin
        n_vec++; if (if0.tx_out !== e_4c01_p0[19 - c/4]) begin
          n_err++; $display("FAIL busy_start_tx c=%0d got %b exp %b", c, if0.tx_out, e_4c01_p0[19 - c/4]);
        end
      end
      if (if0.frame_done === 1'b1) dones++;
      if (c >= 80 && (if0.tx_out !== 1'b1 || if0.busy !== 1'b0)) lows++;
      tick();
    end
    n_vec++; if (dones !== 1) begin n_err++; $display("FAIL busy_start_done_count got %0d exp 1", dones); end
    n_vec++; if (lows !== 0) begin n_err++; $display("FAIL busy_start_second_frame got %0d active cycles exp 0", lows); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_parity();
    test_periodic();
    test_enable_drop();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
